// File: rtl/reduce_check_pkg.sv
// Shared types and constants for the reduce_checker block.
//   state_t    : run-control FSM state (2-bit encoding)
//   count_t    : 16-bit counter/index type used on all result outputs
//   NO_ERR_IDX : first_err_idx value meaning "no mismatch seen"
//   sat_inc    : saturating +1 for count_t
package reduce_check_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef logic [15:0] count_t;

  localparam count_t NO_ERR_IDX = 16'hFFFF;
  localparam count_t CNT_MAX    = 16'hFFFF;

  function automatic count_t sat_inc(input count_t c);
    return (c == CNT_MAX) ? c : c + 16'd1;
  endfunction

endpackage

// File: rtl/reduce_compare.sv
// Combinational stage-2 compare of one beat.
// Each reduction operator is checked against an independently formed
// reference; any disagreement flags the beat as a mismatch.
//   data       : registered stage-1 vector (WIDTH bits)
//   inject_err : inverts the and-reduce reference to force a mismatch
//   mismatch   : 1 when any reduce/reference pair differs
//   all_ones   : and-reduce result
module reduce_compare
  import reduce_check_pkg::*;
#(
  parameter int WIDTH = 68
) (
  input  logic [WIDTH-1:0] data,
  input  logic             inject_err,
  output logic             mismatch,
  output logic             all_ones
);

  logic w_and, w_or, w_xor;
  logic w_and_ref, w_or_ref, w_par_ref;

  assign w_and = &data;
  assign w_or  = |data;
  assign w_xor = ^data;

  assign w_and_ref = (data == {WIDTH{1'b1}}) ^ inject_err;
  assign w_or_ref  = (data != '0);

  // Bitwise parity walk, deliberately not using the ^ reduction operator.
  always_comb begin
    w_par_ref = 1'b0;
    for (int i = 0; i < WIDTH; i++) w_par_ref = w_par_ref ^ data[i];
  end

  assign mismatch = (w_and != w_and_ref) | (w_or != w_or_ref) | (w_xor != w_par_ref);
  assign all_ones = w_and;

endmodule

// File: rtl/reduce_checker.sv
// Reduce-operator self-checker. A run (started by start) accepts
// NUM_VECTORS beats over a valid/ready handshake, checks each beat's
// and/or/xor reductions in a two-stage pipeline and accumulates results.
//   clock, reset (sync, active low)
//   start, clear         : run control (start wins over clear in DONE)
//   in_valid/in_ready    : beat handshake, in_data WIDTH bits, inject_err
//   busy, done, pass     : status
//   err_count, ones_count: saturating 16-bit counts
//   first_err_idx        : index of first mismatching beat, FFFF if none
module reduce_checker
  import reduce_check_pkg::*;
#(
  parameter int WIDTH       = 68,
  parameter int NUM_VECTORS = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             inject_err,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output count_t           err_count,
  output count_t           ones_count,
  output count_t           first_err_idx
);

  localparam count_t NV      = count_t'(NUM_VECTORS);
  localparam count_t NV_LAST = count_t'(NUM_VECTORS - 1);

  state_t           r_state, w_next;
  count_t           r_beat_idx;
  logic [1:0]       r_vld_pipe;  // [0] stage 1, [1] stage 2
  logic [WIDTH-1:0] r_s1_data;
  logic             r_s1_inj;
  count_t           r_s1_idx;
  logic             r_s2_mis, r_s2_ones;
  count_t           r_s2_idx;
  count_t           r_err_cnt, r_ones_cnt, r_first_err;

  logic w_accept, w_start_run, w_mis, w_all_ones;

  assign in_ready    = (r_state == ST_RUN) && (r_beat_idx < NV);
  assign w_accept    = in_valid && in_ready;
  assign w_start_run = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (start) w_next = ST_RUN;
      ST_RUN:   if (w_accept && (r_beat_idx == NV_LAST)) w_next = ST_DRAIN;
      ST_DRAIN: if (r_vld_pipe == 2'b00) w_next = ST_DONE;
      ST_DONE:  if (start) w_next = ST_RUN;
                else if (clear) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Control state and results.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_vld_pipe  <= 2'b00;
      r_beat_idx  <= '0;
      r_err_cnt   <= '0;
      r_ones_cnt  <= '0;
      r_first_err <= NO_ERR_IDX;
    end else begin
      r_state    <= w_next;
      r_vld_pipe <= {r_vld_pipe[0], w_accept};
      // Pipeline is empty in IDLE/DONE, so a fresh start never races a
      // retiring beat.
      if (w_start_run) begin
        r_beat_idx  <= '0;
        r_err_cnt   <= '0;
        r_ones_cnt  <= '0;
        r_first_err <= NO_ERR_IDX;
      end else begin
        if (w_accept) r_beat_idx <= r_beat_idx + 16'd1;
        if (r_vld_pipe[1]) begin
          if (r_s2_mis) begin
            r_err_cnt <= sat_inc(r_err_cnt);
            // err count saturates rather than wraps, so zero means "first".
            if (r_err_cnt == '0) r_first_err <= r_s2_idx;
          end
          if (r_s2_ones) r_ones_cnt <= sat_inc(r_ones_cnt);
        end
      end
    end
  end

  // Datapath: no reset, qualified by r_vld_pipe.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_s1_data <= in_data;
      r_s1_inj  <= inject_err;
      r_s1_idx  <= r_beat_idx;
    end
    r_s2_mis  <= w_mis;
    r_s2_ones <= w_all_ones;
    r_s2_idx  <= r_s1_idx;
  end

  reduce_compare #(.WIDTH(WIDTH)) u_cmp (
    .data       (r_s1_data),
    .inject_err (r_s1_inj),
    .mismatch   (w_mis),
    .all_ones   (w_all_ones)
  );

  assign busy          = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign done          = (r_state == ST_DONE);
  assign pass          = (r_state == ST_DONE) && (r_err_cnt == '0);
  assign err_count     = r_err_cnt;
  assign ones_count    = r_ones_cnt;
  assign first_err_idx = r_first_err;

endmodule

// File: tb/tb_reduce_checker.sv
// Scoreboard bench for reduce_checker (WIDTH=68, NUM_VECTORS=4).
// The driver computes each run's expected result from the beats it offers
// and pushes it into exp_q; the monitor pops on each rising done.
module tb_reduce_checker;
  import reduce_check_pkg::*;

  localparam int W  = 68;
  localparam int NV = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0, clear = 1'b0, in_valid = 1'b0, inject_err = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready, busy, done, pass;
  logic [15:0]  err_count, ones_count, first_err_idx;

  reduce_checker #(.WIDTH(W), .NUM_VECTORS(NV)) dut (
    .clock(clock), .reset(reset), .start(start), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .inject_err(inject_err), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .ones_count(ones_count), .first_err_idx(first_err_idx)
  );

  always #5 clock = ~clock;

  int total = 0, bad = 0;

  typedef struct { int err; int ones; int first; int pass; } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // ---------------- monitor ----------------
  int   cyc = 0, acc_cnt = 0, last_acc = 0;
  logic prev_done = 1'b0;
  exp_t e;

  always @(negedge clock) begin
    cyc++;
    if (!reset) acc_cnt = 0;
    else if (in_valid && in_ready) begin
      acc_cnt++;
      last_acc = cyc;
    end
    if (reset && done && !prev_done) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done: actual=1 required=0");
      end else begin
        e = exp_q.pop_front();
        chk("mon_err_count", err_count, e.err);
        chk("mon_ones_count", ones_count, e.ones);
        chk("mon_first_err_idx", first_err_idx, e.first);
        chk("mon_pass", pass, e.pass);
        chk("mon_acceptances", acc_cnt, NV);
        // Accept edge follows the sampling negedge; done rises 3 edges
        // later and is first seen on the 4th negedge.
        chk("mon_done_latency", cyc - last_acc, 4);
        chk("mon_in_ready_after", in_ready, 0);
      end
      acc_cnt = 0;
    end
    prev_done = done;
  end

  // ---------------- driver + reference model ----------------
  int m_err, m_ones, m_first, m_idx;

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic model_clear();
    m_err = 0; m_ones = 0; m_first = 65535; m_idx = 0;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
    model_clear();
  endtask

  task automatic send(input logic [W-1:0] d, input bit inj);
    int n = 0;
    in_valid = 1'b1; in_data = d; inject_err = inj;
    while (!in_ready && n < 20) begin tick(); n++; end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL in_ready_timeout: actual=0 required=1");
    end else begin
      // Reductions agree with their references unless inject is set.
      if (inj) begin
        if (m_err == 0) m_first = m_idx;
        if (m_err < 65535) m_err++;
      end
      if (d == {W{1'b1}}) m_ones++;
      m_idx++;
    end
    tick();
    in_valid = 1'b0; inject_err = 1'b0;
  endtask

  task automatic finish_run();
    int n = 0;
    exp_t x;
    x.err = m_err; x.ones = m_ones; x.first = m_first; x.pass = (m_err == 0) ? 1 : 0;
    exp_q.push_back(x);
    while (!done && n < 30) begin tick(); n++; end
    if (!done) begin
      total++; bad++;
      $display("FAIL done_timeout: actual=0 required=1");
    end
    tick();  // let the monitor see done before moving on
  endtask

  task automatic run4(input logic [W-1:0] b0, b1, b2, b3,
                      input bit [3:0] inj, input bit gap);
    logic [W-1:0] bq[4];
    bq[0] = b0; bq[1] = b1; bq[2] = b2; bq[3] = b3;
    do_start();
    for (int i = 0; i < 4; i++) begin
      send(bq[i], inj[i]);
      if (gap) tick();
    end
    finish_run();
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  function automatic logic [W-1:0] rnd_beat();
    logic [W-1:0] d;
    case ($urandom_range(0, 3))
      0: d = {W{1'b1}};
      1: begin d = {W{1'b1}}; d[W-1] = 1'b0; end
      2: d = '0;
      default: begin
        d[31:0]  = $urandom();
        d[63:32] = $urandom();
        d[67:64] = 4'($urandom());
      end
    endcase
    return d;
  endfunction

  localparam logic [W-1:0] B_FE  = 68'hF_FFFF_FFFF_FFFF_FFFE;
  localparam logic [W-1:0] B_FF  = 68'hF_FFFF_FFFF_FFFF_FFFF;
  localparam logic [W-1:0] B_TOP = 68'h8_0000_0000_0000_0000;
  localparam logic [W-1:0] B_LO  = 68'h0_FFFF_FFFF_FFFF_FFFF;

  initial begin
    model_clear();
    reset = 1'b0;
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_ones_count", ones_count, 0);
    chk("rst_first_err_idx", first_err_idx, 16'hFFFF);
    reset = 1'b1;
    tick();

    // Clean run; bit-67-only beat must not count as all-ones.
    run4(B_FE, B_FF, '0, B_TOP, 4'b0000, 1'b0);
    repeat (3) tick();
    chk("hold_done", done, 1);
    chk("hold_ones", ones_count, 1);
    chk("clean_pass", pass, 1);
    do_clear();
    chk("clear_done", done, 0);
    chk("clear_busy", busy, 0);
    chk("clear_keep_ones", ones_count, 1);

    // Inject on beat 1.
    run4(B_FE, B_FF, '0, B_LO, 4'b0010, 1'b0);
    chk("inj_err_count", err_count, 1);
    chk("inj_first_err_idx", first_err_idx, 1);
    chk("inj_pass", pass, 0);
    do_clear();
    chk("clear_keep_err", err_count, 1);

    // in_valid every other cycle.
    run4(B_LO, B_FF, rnd_beat(), rnd_beat(), 4'b0100, 1'b1);

    // Reset mid-run after two beats; in-flight beats discarded.
    do_start();
    send(B_FF, 1'b1);
    send(B_FF, 1'b0);
    reset = 1'b0; tick(); reset = 1'b1;
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 0);
    tick();
    chk("midrst_err_count", err_count, 0);
    chk("midrst_ones_count", ones_count, 0);
    chk("midrst_first_err_idx", first_err_idx, 16'hFFFF);
    chk("midrst_done", done, 0);
    run4(B_FF, B_FE, B_FF, B_TOP, 4'b1000, 1'b0);

    // start and clear together in DONE: start wins, counters fresh.
    start = 1'b1; clear = 1'b1; tick(); start = 1'b0; clear = 1'b0;
    model_clear();
    chk("sc_busy", busy, 1);
    chk("sc_done", done, 0);
    chk("sc_err_count", err_count, 0);
    chk("sc_ones_count", ones_count, 0);
    chk("sc_first_err_idx", first_err_idx, 16'hFFFF);
    for (int i = 0; i < 4; i++) send(rnd_beat(), i == 2);
    finish_run();

    // Random runs.
    for (int r = 0; r < 8; r++) begin
      if ($urandom_range(0, 1) == 1) do_clear();
      run4(rnd_beat(), rnd_beat(), rnd_beat(), rnd_beat(),
           4'($urandom_range(0, 15) & $urandom_range(0, 15)),
           $urandom_range(0, 1) == 1);
    end

    repeat (5) tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
